// File: rtl/hazard_forward_unit_pkg.sv
// Shared pipeline types for the hazard/forwarding unit: select codes, stage tags
// and the operand-select function applied to each source register.
package hazard_forward_unit_pkg;

  localparam int NREG_BITS = 5;
  localparam int CNT_BITS  = 16;

  typedef enum logic [1:0] {
    FWD_RF       = 2'b00,
    FWD_WB       = 2'b01,
    FWD_MEM_ALU  = 2'b10,
    FWD_MEM_LINK = 2'b11
  } fwd_sel_t;

  typedef struct packed {
    logic                 valid;
    logic [NREG_BITS-1:0] rd;
    logic                 regwrite;
    logic                 memread;
    logic                 link;
  } hz_tag_t;

  function automatic logic tag_produces(hz_tag_t tag, logic [NREG_BITS-1:0] rs);
    return tag.valid && tag.regwrite && (tag.rd != '0) && (tag.rd == rs);
  endfunction

  // EX is checked first so the newest producer wins; its value sits in MEM when
  // the consumer reaches EX, hence the MEM-side codes.
  function automatic fwd_sel_t fwd_select(hz_tag_t ex_tag, hz_tag_t mem_tag,
                                          logic [NREG_BITS-1:0] rs);
    if (tag_produces(ex_tag, rs))
      return ex_tag.link ? FWD_MEM_LINK : FWD_MEM_ALU;
    if (tag_produces(mem_tag, rs))
      return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Decode-side inputs and hazard/forwarding outputs of the hazard unit.
interface hazard_forward_unit_if #(parameter int CNT_BITS = 16);
  import hazard_forward_unit_pkg::*;

  logic                 id_valid;
  logic [NREG_BITS-1:0] id_rs1;
  logic [NREG_BITS-1:0] id_rs2;
  logic [NREG_BITS-1:0] id_rd;
  logic                 id_regwrite;
  logic                 id_memread;
  logic                 id_link;
  logic                 flush;
  fwd_sel_t             fwd_a_sel;
  fwd_sel_t             fwd_b_sel;
  logic                 stall;
  logic                 bubble;
  logic [CNT_BITS-1:0]  stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, id_link, flush,
    input  fwd_a_sel, fwd_b_sel, stall, bubble, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, id_link, flush,
    output fwd_a_sel, fwd_b_sel, stall, bubble, stall_count
  );
endinterface

// File: rtl/hazard_forward_unit_hz_tag_reg.sv
// One pipeline-stage destination tag; takes d when load is high, else a bubble.
// One-cycle latency, no backpressure of its own.
module hz_tag_reg
  import hazard_forward_unit_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    load,
  input  hz_tag_t d,
  output hz_tag_t q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      q <= '0;
    else if (load)
      q <= d;
    else
      q <= '0;
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// EX-operand forwarding selects (registered on ID->EX) and load-use stall/bubble
// (combinational, same cycle), plus a saturating stall counter.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int CNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  hazard_forward_unit_if.slave  hif
);

  hz_tag_t             id_tag;
  hz_tag_t             ex_tag;
  hz_tag_t             mem_tag;
  hz_tag_t             wb_tag;
  logic                hazard;
  logic                ex_load;
  fwd_sel_t            sel_a;
  fwd_sel_t            sel_b;
  logic [CNT_BITS-1:0] stall_cnt;
  logic                unused_wb;

  always_comb begin
    id_tag          = '0;
    id_tag.valid    = hif.id_valid;
    id_tag.rd       = hif.id_rd;
    id_tag.regwrite = hif.id_regwrite;
    id_tag.memread  = hif.id_memread;
    id_tag.link     = hif.id_link;
  end

  // A flush squashes the ID instruction anyway, so it suppresses the stall.
  assign hazard = hif.id_valid && ex_tag.valid && ex_tag.memread && (ex_tag.rd != '0) &&
                  ((ex_tag.rd == hif.id_rs1) || (ex_tag.rd == hif.id_rs2)) && !hif.flush;

  assign ex_load = hif.id_valid && !hazard && !hif.flush;

  hz_tag_reg u_ex_tag  (.clk(clk), .reset(reset), .load(ex_load), .d(id_tag),  .q(ex_tag));
  hz_tag_reg u_mem_tag (.clk(clk), .reset(reset), .load(1'b1),    .d(ex_tag),  .q(mem_tag));
  hz_tag_reg u_wb_tag  (.clk(clk), .reset(reset), .load(1'b1),    .d(mem_tag), .q(wb_tag));

  // The WB tag has no consumer yet; the writeback value itself arrives via the datapath.
  assign unused_wb = ^wb_tag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_a <= FWD_RF;
      sel_b <= FWD_RF;
    end else if (ex_load) begin
      sel_a <= fwd_select(ex_tag, mem_tag, hif.id_rs1);
      sel_b <= fwd_select(ex_tag, mem_tag, hif.id_rs2);
    end else begin
      sel_a <= FWD_RF;
      sel_b <= FWD_RF;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (hazard && (stall_cnt != {CNT_BITS{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign hif.fwd_a_sel   = sel_a;
  assign hif.fwd_b_sel   = sel_b;
  assign hif.stall       = hazard;
  assign hif.bubble      = hazard;
  assign hif.stall_count = stall_cnt;

endmodule
